// File: rtl/video_pkg.sv
// Shared types and constants for the video capture sink.
// Pixel, coordinate and BRAM address widths plus error flag bit positions.
package video_pkg;

  localparam int COORDW = 13;
  localparam int ADDRW  = 17;
  localparam int PIXW   = 24;

  typedef logic [PIXW-1:0]   pixel_t;
  typedef logic [COORDW-1:0] coord_t;
  typedef logic [ADDRW-1:0]  addr_t;

  localparam int ERR_EOL_EARLY = 0;
  localparam int ERR_EOL_LATE  = 1;
  localparam int ERR_SOF_MID   = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/video_pos_tracker.sv
// Tracks the x/y raster position of each accepted beat and raises sticky line/frame
// protocol errors while a capture is in progress.
module video_pos_tracker
  import video_pkg::*;
#(
  parameter int SCRW = 1280
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       beat,
  input  logic       tuser,
  input  logic       tlast,
  input  logic       in_wait,
  input  logic       in_capture,
  input  logic       clr_err,
  output coord_t     cur_x,
  output coord_t     cur_y,
  output logic       pix_ok,
  output logic       sof,
  output logic       eol,
  output logic [2:0] err
);

  localparam coord_t X_LAST = coord_t'(SCRW - 1);
  localparam coord_t X_SAT  = coord_t'(SCRW);

  coord_t     x_q, y_q, x_d, y_d;
  logic [2:0] err_q, err_set;
  logic       chk_en;

  always_comb begin
    sof    = beat & tuser;
    eol    = beat & tlast;
    // an SOF beat is always treated as pixel (0,0), whatever came before it
    cur_x  = sof ? '0 : x_q;
    cur_y  = sof ? '0 : y_q;
    pix_ok = beat & (cur_x < X_SAT);
    chk_en = in_capture | (in_wait & sof);
    x_d    = x_q;
    y_d    = y_q;
    if (beat) begin
      if (tlast) begin
        x_d = '0;
        y_d = cur_y + 1'b1;
      end else begin
        x_d = pix_ok ? cur_x + 1'b1 : cur_x;
        y_d = cur_y;
      end
    end
    err_set                = '0;
    err_set[ERR_SOF_MID]   = sof & in_capture & ((x_q != '0) | (y_q != '0));
    err_set[ERR_EOL_EARLY] = chk_en & eol & (cur_x < X_LAST);
    err_set[ERR_EOL_LATE]  = chk_en & beat & (cur_x == X_SAT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q   <= '0;
      y_q   <= '0;
      err_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      err_q <= clr_err ? '0 : (err_q | err_set);
    end
  end

  assign err = err_q;

endmodule

// File: rtl/video_capture.sv
// AXI4-Stream video sink: writes one rectangular window of one armed frame into a BRAM.
// state       | meaning
// ST_IDLE     | not armed, stream is accepted and discarded
// ST_WAIT_SOF | armed, discarding until a beat with tuser
// ST_CAPTURE  | writing in-window pixels of the current frame
// ST_DONE     | frame captured, done held until the next arm
module video_capture
  import video_pkg::*;
#(
  parameter int DATAW = 32,
  parameter int SCRW  = 1280,
  parameter int SCRH  = 720,
  parameter int IMGW  = 320,
  parameter int IMGH  = 240
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [12:0]      win_x,
  input  logic [12:0]      win_y,
  input  logic [DATAW-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tlast,
  output logic             bram_en_o,
  output logic             bram_we_o,
  output logic [16:0]      bram_addr_o,
  output logic [23:0]      bram_data_o,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt,
  output logic [2:0]       err
);

  if (DATAW < PIXW) begin : g_bad_dataw
    $error("video_capture: DATAW must be >= 24");
  end
  if (IMGW * IMGH > 131072) begin : g_bad_img
    $error("video_capture: IMGW*IMGH must be <= 131072");
  end
  if (DATAW > PIXW) begin : g_unused_tdata
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata[DATAW-1:PIXW];
  end

  localparam logic [COORDW:0] IMGW_C   = (COORDW+1)'(IMGW);
  localparam logic [COORDW:0] IMGH_C   = (COORDW+1)'(IMGH);
  localparam coord_t          Y_LAST   = coord_t'(SCRH - 1);
  localparam addr_t           ROW_STEP = addr_t'(IMGW);

  cap_state_t state_q, state_d;
  logic       tready_q, beat;
  coord_t     wx_q, wy_q, cur_x, cur_y;
  addr_t      row_base_q, row_base_d, rb_cur, addr_q;
  pixel_t     data_q;
  logic       pix_ok, sof, eol, cap, in_row, in_col, wr, last, arm_ok;
  logic       we_q, done_q;
  logic [15:0] cnt_q;

  assign beat = s_axis_tvalid & tready_q;

  video_pos_tracker #(.SCRW(SCRW)) u_pos (
    .clk        (clk),
    .rst        (rst),
    .beat       (beat),
    .tuser      (s_axis_tuser),
    .tlast      (s_axis_tlast),
    .in_wait    (state_q == ST_WAIT_SOF),
    .in_capture (state_q == ST_CAPTURE),
    .clr_err    (arm_ok),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .pix_ok     (pix_ok),
    .sof        (sof),
    .eol        (eol),
    .err        (err)
  );

  always_comb begin
    cap    = (state_q == ST_CAPTURE) | ((state_q == ST_WAIT_SOF) & sof);
    rb_cur = sof ? '0 : row_base_q;
    in_row = (cur_y >= wy_q) && ({1'b0, cur_y} < ({1'b0, wy_q} + IMGH_C));
    in_col = pix_ok && (cur_x >= wx_q) && ({1'b0, cur_x} < ({1'b0, wx_q} + IMGW_C));
    wr     = cap & in_row & in_col;
    last   = cap & eol & (cur_y == Y_LAST);
    arm_ok = 1'b0;
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          arm_ok  = 1'b1;
          state_d = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF: if (sof) state_d = last ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE:  if (last) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
    row_base_d = row_base_q;
    if (arm_ok) row_base_d = '0;
    else if (cap) row_base_d = (eol & in_row) ? rb_cur + ROW_STEP : rb_cur;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      tready_q   <= 1'b0;
      wx_q       <= '0;
      wy_q       <= '0;
      row_base_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tready_q   <= 1'b1;
      row_base_q <= row_base_d;
      we_q       <= wr;
      if (arm_ok) begin
        wx_q   <= win_x;
        wy_q   <= win_y;
        done_q <= 1'b0;
      end
      if (wr) begin
        addr_q <= rb_cur + addr_t'(cur_x - wx_q);
        data_q <= s_axis_tdata[PIXW-1:0];
      end
      if (last) begin
        done_q <= 1'b1;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign s_axis_tready = tready_q;
  assign bram_en_o     = we_q;
  assign bram_we_o     = we_q;
  assign bram_addr_o   = addr_q;
  assign bram_data_o   = data_q;
  assign busy          = (state_q == ST_WAIT_SOF) | (state_q == ST_CAPTURE);
  assign done          = done_q;
  assign frame_cnt     = cnt_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a 16x8 screen with a 4x2 capture window.
module tb_video_capture;

  localparam int SCRW = 16;
  localparam int SCRH = 8;
  localparam int IMGW = 4;
  localparam int IMGH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic [12:0] win_x = '0;
  logic [12:0] win_y = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tuser = 1'b0;
  logic        tlast = 1'b0;
  logic        tready, bram_en_o, bram_we_o, busy, done;
  logic [16:0] bram_addr_o;
  logic [23:0] bram_data_o;
  logic [15:0] frame_cnt;
  logic [2:0]  err;

  video_capture #(.DATAW(32), .SCRW(SCRW), .SCRH(SCRH), .IMGW(IMGW), .IMGH(IMGH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .win_x(win_x), .win_y(win_y),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tuser(tuser), .s_axis_tlast(tlast),
    .bram_en_o(bram_en_o), .bram_we_o(bram_we_o), .bram_addr_o(bram_addr_o),
    .bram_data_o(bram_data_o), .busy(busy), .done(done), .frame_cnt(frame_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_n = 0;
  logic [16:0] wr_addr [128];
  logic [23:0] wr_data [128];
  int          wr_cyc  [128];
  int          exp_cyc [128];
  int          exp_n = 0;
  int          tready_low = 0;
  int          en_bad = 0;
  logic        mon_on = 1'b0;
  logic        gap_en = 1'b0;

  always @(negedge clk) begin
    if (bram_we_o && wr_n < 128) begin
      wr_addr[wr_n] = bram_addr_o;
      wr_data[wr_n] = bram_data_o;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (bram_en_o !== bram_we_o) en_bad++;
    if (mon_on && tready !== 1'b1) tready_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic in_win(input int x, input int y, input int wx, input int wy);
    return (x < SCRW) && (x >= wx) && (x < wx + IMGW) && (y >= wy) && (y < wy + IMGH);
  endfunction

  task automatic send_beat(input logic [23:0] pix, input logic u, input logic l, input logic w);
    int g;
    if (gap_en) begin
      g = int'($urandom_range(0, 1));
      tvalid = 1'b0;
      repeat (g) tick();
    end
    tdata  = {8'hA5, pix};
    tuser  = u;
    tlast  = l;
    tvalid = 1'b1;
    tick();
    if (w && exp_n < 128) begin
      exp_cyc[exp_n] = cyc;
      exp_n++;
    end
    tvalid = 1'b0;
    tuser  = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_line(input logic [23:0] base, input int y, input int n, input logic sof,
                           input logic eol, input int wx, input int wy);
    for (int x = 0; x < n; x++)
      send_beat(base | 24'(y * 16 + x), sof && x == 0, eol && x == n - 1, in_win(x, y, wx, wy));
  endtask

  task automatic send_frame(input logic [23:0] base, input int wx, input int wy, input int short_y);
    for (int y = 0; y < SCRH; y++)
      send_line(base, y, (y == short_y) ? 11 : SCRW, y == 0, 1'b1, wx, wy);
  endtask

  task automatic do_arm(input int wx, input int wy);
    win_x = 13'(wx);
    win_y = 13'(wy);
    arm   = 1'b1;
    tick();
    arm   = 1'b0;
  endtask

  task automatic check_window(input int b, input logic [23:0] base);
    for (int i = 0; i < 8; i++) begin
      check("win_addr", 32'(wr_addr[b + i]), 32'(i));
      check("win_data", 32'(wr_data[b + i]), 32'(base | 24'((i < 4) ? 'h32 + i : 'h42 + i - 4)));
    end
  endtask

  task automatic check_timing(input int b);
    for (int i = 0; i < 8; i++)
      check("wr_latency", 32'(wr_cyc[b + i]), 32'(exp_cyc[b + i]));
  endtask

  int b;

  initial begin
    // reset state
    tick();
    tick();
    check("rst_tready", 32'(tready), 0);
    check("rst_en", 32'(bram_en_o), 0);
    check("rst_we", 32'(bram_we_o), 0);
    check("rst_addr", 32'(bram_addr_o), 0);
    check("rst_data", 32'(bram_data_o), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b1;
    tick();
    check("tready_after_rst", 32'(tready), 1);
    mon_on = 1'b1;

    // unarmed frame is discarded
    exp_n = wr_n;
    send_frame(24'h0, 2, 3, -1);
    tick();
    check("noarm_writes", 32'(wr_n), 0);
    check("noarm_done", 32'(done), 0);
    check("noarm_busy", 32'(busy), 0);
    check("noarm_tready_low", 32'(tready_low), 0);

    // armed capture of one frame, second frame ignored
    b = wr_n;
    exp_n = b;
    do_arm(2, 3);
    check("arm_busy", 32'(busy), 1);
    check("arm_done", 32'(done), 0);
    send_frame(24'h0, 2, 3, -1);
    check("f1_done", 32'(done), 1);
    check("f1_frame_cnt", 32'(frame_cnt), 1);
    check("f1_busy", 32'(busy), 0);
    tick();
    check("f1_writes", 32'(wr_n - b), 8);
    check_window(b, 24'h0);
    check_timing(b);
    check("f1_err", 32'(err), 0);
    send_frame(24'h0, 2, 3, -1);
    tick();
    check("f2_writes", 32'(wr_n - b), 8);
    check("f2_frame_cnt", 32'(frame_cnt), 1);
    check("f2_done", 32'(done), 1);

    // capture with random valid gaps
    b = wr_n;
    exp_n = b;
    do_arm(2, 3);
    check("rearm_done_clr", 32'(done), 0);
    gap_en = 1'b1;
    send_frame(24'h0, 2, 3, -1);
    gap_en = 1'b0;
    tick();
    check("gap_writes", 32'(wr_n - b), 8);
    check_window(b, 24'h0);
    check_timing(b);
    check("gap_frame_cnt", 32'(frame_cnt), 2);
    check("gap_done", 32'(done), 1);

    // early EOL on line 1
    b = wr_n;
    do_arm(2, 3);
    send_frame(24'h0, 2, 3, 1);
    tick();
    check("early_err", 32'(err), 3'b001);
    check("early_writes", 32'(wr_n - b), 8);
    check_window(b, 24'h0);
    check("early_done", 32'(done), 1);
    check("early_frame_cnt", 32'(frame_cnt), 3);

    // SOF at (5,4) restarts the capture
    b = wr_n;
    do_arm(2, 3);
    check("arm_err_clr", 32'(err), 0);
    for (int y = 0; y < 4; y++) send_line(24'h0, y, SCRW, y == 0, 1'b1, 2, 3);
    send_line(24'h0, 4, 5, 1'b0, 1'b0, 2, 3);
    check("mid_done_before", 32'(done), 0);
    send_frame(24'h010000, 2, 3, -1);
    tick();
    check("sofmid_err", 32'(err), 3'b100);
    check("sofmid_writes", 32'(wr_n - b), 15);
    check("sofmid_old_addr", 32'(wr_addr[b + 6]), 6);
    check("sofmid_old_data", 32'(wr_data[b + 6]), 'h44);
    check_window(b + 7, 24'h010000);
    check("sofmid_done", 32'(done), 1);
    check("sofmid_frame_cnt", 32'(frame_cnt), 4);

    // over-long line 0 with window reaching past the screen edge, then reset mid-capture
    b = wr_n;
    do_arm(14, 0);
    send_line(24'h0, 0, 20, 1'b1, 1'b1, 14, 0);
    check("late_err", 32'(err), 3'b010);
    check("late_writes", 32'(wr_n - b), 2);
    check("late_addr0", 32'(wr_addr[b]), 0);
    check("late_data0", 32'(wr_data[b]), 'h0e);
    check("late_addr1", 32'(wr_addr[b + 1]), 1);
    check("late_data1", 32'(wr_data[b + 1]), 'h0f);
    send_line(24'h0, 1, 15, 1'b0, 1'b0, 14, 0);
    check("pend_we", 32'(bram_we_o), 1);
    check("pend_addr", 32'(bram_addr_o), 4);
    check("pend_data", 32'(bram_data_o), 'h1e);
    check("pend_busy", 32'(busy), 1);
    mon_on = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("arst_we", 32'(bram_we_o), 0);
    check("arst_en", 32'(bram_en_o), 0);
    check("arst_addr", 32'(bram_addr_o), 0);
    check("arst_data", 32'(bram_data_o), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_frame_cnt", 32'(frame_cnt), 0);
    check("arst_err", 32'(err), 0);
    check("arst_tready", 32'(tready), 0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("tready_low_total", 32'(tready_low), 0);
    check("en_we_agree", 32'(en_bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
